// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side drain stage.
package fifo_rd_pkg;

    localparam int unsigned WIDTH_DEF      = 8;
    localparam int unsigned SKID_DEPTH_DEF = 2;
    localparam int unsigned CNT_W_DEF      = 16;

    // Width needed to hold an occupancy value of 0..depth inclusive
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned OCC_W_DEF = occ_w(SKID_DEPTH_DEF);

    typedef logic [OCC_W_DEF-1:0] occ_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small ring buffer holding words captured from the FIFO until the sink takes them.
// Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEF,
    parameter  int unsigned DEPTH = SKID_DEPTH_DEF,
    localparam int unsigned OCC_W = occ_w(DEPTH),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [OCC_W-1:0] occ_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             w_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A read only takes effect when there is something to read
    assign w_rd    = rd_i & (r_occ != '0);
    assign rdata_o = r_mem[r_head];
    assign occ_o   = r_occ;

    // Ring storage, pointers and occupancy; flush empties the ring and drops any write
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mem  <= '{default: '0};
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (wr_i) begin
                r_mem[r_tail] <= wdata_i;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_rd) begin
                r_head <= ptr_inc(r_head);
            end
            r_occ <= r_occ + OCC_W'(wr_i) - OCC_W'(w_rd);
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind the async FIFO: pops via rd_en/empty, absorbs the
// one-cycle read latency and presents words on a valid/ready stream.
// Optional statistics counters are built when FIFO_RD_STAT_EN is defined;
// otherwise word_cnt_o/stall_cnt_o are tied to zero.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter  int unsigned WIDTH      = WIDTH_DEF,
    parameter  int unsigned SKID_DEPTH = SKID_DEPTH_DEF,
    parameter  int unsigned CNT_W      = CNT_W_DEF,
    localparam int unsigned OCC_W      = occ_w(SKID_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned CR_W = OCC_W + 1;

    logic             r_inflight;
    logic [OCC_W-1:0] w_occ;
    logic             w_pop;
    logic             w_issue;
    logic             w_capture;
    logic [CR_W-1:0]  w_credit_used;

    // Credit: buffered words plus the word in flight, minus the one leaving this cycle
    assign w_pop         = m_valid_o & m_ready_i;
    assign w_credit_used = CR_W'(w_occ) + CR_W'(r_inflight) - CR_W'(w_pop);
    assign w_issue       = rst_n_i & ~flush_i & ~fifo_empty_i
                         & (w_credit_used < CR_W'(SKID_DEPTH));
    assign fifo_rd_en_o  = w_issue;
    assign w_capture     = r_inflight & ~flush_i;
    assign m_valid_o     = (w_occ != '0);

    // In-flight flag: FIFO data appears the cycle after a pop request
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .wr_i    (w_capture),
        .wdata_i (fifo_rdata_i),
        .rd_i    (w_pop),
        .rdata_o (m_data_o),
        .occ_o   (w_occ)
    );

`ifdef FIFO_RD_STAT_EN
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Delivered-word count wraps; back-pressure count saturates; flush leaves both alone
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (m_valid_o && !m_ready_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign word_cnt_o  = r_word_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    assign word_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

    // Every captured word must have a free slot
    a_credit: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (CR_W'(w_occ) + CR_W'(r_inflight)) <= CR_W'(SKID_DEPTH))
        else $error("skid buffer over-committed");

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO source, scoreboard of expected words,
// and an independent monitor checking the stream, counters and handshake rules.
module tb_fifo_rd_stream;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 16;

    logic             clk_i        = 1'b0;
    logic             rst_n_i      = 1'b0;
    logic             flush_i      = 1'b0;
    logic             fifo_empty_i = 1'b0;
    logic [WIDTH-1:0] fifo_rdata_i = '0;
    logic             fifo_rd_en_o;
    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i    = 1'b0;
    logic [CNT_W-1:0] word_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    always #5 clk_i = ~clk_i;

    fifo_rd_stream #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .word_cnt_o   (word_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] src[$];
    logic [WIDTH-1:0] exp_q[$];

    int          p_ready    = 100;
    int          p_empty    = 0;
    bit          tgl_mode   = 1'b0;
    bit          flush_req  = 1'b0;
    bit          rel_req    = 1'b0;
    bit          have_pend  = 1'b0;
    logic [WIDTH-1:0] pend_word = '0;
    logic        last_rd_en = 1'b0;
    int          rd_run     = 0;
    int          rd_run_max = 0;
    int          cyc        = 0;
    logic        forced;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; models the FIFO's pop and one-cycle read latency
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        if (rel_req) begin
            rst_n_i = 1'b1;
            rel_req = 1'b0;
        end
        fifo_rdata_i = have_pend ? pend_word : WIDTH'($urandom);
        have_pend    = 1'b0;
        m_ready_i    = ($urandom_range(99) < p_ready);
        forced       = tgl_mode ? cyc[0] : ($urandom_range(99) < p_empty);
        fifo_empty_i = forced || (src.size() == 0);
        flush_i      = flush_req;
        flush_req    = 1'b0;
        @(negedge clk_i);
        last_rd_en = fifo_rd_en_o;
        check("rd_en_gated", 32'(fifo_rd_en_o & (fifo_empty_i | ~rst_n_i | flush_i)), 32'(0));
        if (fifo_rd_en_o && !fifo_empty_i && rst_n_i && !flush_i && src.size() != 0) begin
            pend_word = src.pop_front();
            have_pend = 1'b1;
            exp_q.push_back(pend_word);
        end
        rd_run = fifo_rd_en_o ? rd_run + 1 : 0;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
    endtask

    // Asynchronous reset landing mid-cycle
    task automatic reset_mid();
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rst_rd_en", 32'(fifo_rd_en_o), 32'(0));
        check("rst_valid", 32'(m_valid_o), 32'(0));
        check("rst_data", 32'(m_data_o), 32'(0));
        check("rst_word_cnt", 32'(word_cnt_o), 32'(0));
        check("rst_stall_cnt", 32'(stall_cnt_o), 32'(0));
        exp_q.delete();
        have_pend = 1'b0;
    endtask

    task automatic drain();
        p_ready  = 100;
        p_empty  = 0;
        tgl_mode = 1'b0;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || src.size() != 0); i++) step();
        step();
        step();
        check("drain_left", 32'(exp_q.size() + src.size()), 32'(0));
        check("drain_valid", 32'(m_valid_o), 32'(0));
    endtask

    // Monitor: scoreboard compare on each handshake plus stream/counter rules
    logic [CNT_W-1:0] mw, ms;
    logic             pv, pr, pf;
    logic [WIDTH-1:0] pd;
    initial begin
        mw = '0; ms = '0; pv = 1'b0; pr = 1'b0; pf = 1'b0; pd = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                mw = '0; ms = '0; pv = 1'b0; pf = 1'b0;
            end else begin
`ifdef FIFO_RD_STAT_EN
                check("word_cnt", 32'(word_cnt_o), 32'(mw));
                check("stall_cnt", 32'(stall_cnt_o), 32'(ms));
`else
                check("word_cnt_tied", 32'(word_cnt_o), 32'(0));
                check("stall_cnt_tied", 32'(stall_cnt_o), 32'(0));
`endif
                if (pf) check("flush_clears_valid", 32'(m_valid_o), 32'(0));
                if (pv && !pr && !pf) begin
                    check("hold_valid", 32'(m_valid_o), 32'(1));
                    check("hold_data", 32'(m_data_o), 32'(pd));
                end
                if (m_valid_o && m_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", m_data_o, $time);
                    end else begin
                        check("stream_data", 32'(m_data_o), 32'(exp_q.pop_front()));
                    end
                    mw = mw + CNT_W'(1);
                end
                if (m_valid_o && !m_ready_i && ms != '1) ms = ms + CNT_W'(1);
                if (flush_i) exp_q.delete();
                pv = m_valid_o; pr = m_ready_i; pd = m_data_o; pf = flush_i;
            end
        end
    end

    initial begin
        // Reset with FIFO non-empty
        for (int i = 0; i < 4; i++) src.push_back(WIDTH'(8'hA1 + i));
        fifo_empty_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("init_rd_en", 32'(fifo_rd_en_o), 32'(0));
        check("init_valid", 32'(m_valid_o), 32'(0));
        check("init_data", 32'(m_data_o), 32'(0));

        // Release: pop in the first cycle, valid two cycles later
        p_ready = 100; p_empty = 0;
        rel_req = 1'b1;
        step();
        check("rel_first_rd_en", 32'(last_rd_en), 32'(1));
        check("rel_valid_n", 32'(m_valid_o), 32'(0));
        step();
        check("rel_valid_n1", 32'(m_valid_o), 32'(0));
        step();
        check("rel_valid_n2", 32'(m_valid_o), 32'(1));
        drain();

        // Back-to-back stream of 16 words
        for (int i = 1; i <= 16; i++) src.push_back(WIDTH'(i));
        rd_run = 0; rd_run_max = 0;
        repeat (20) step();
        check("b2b_rd_en_run", 32'(rd_run_max), 32'(16));
        drain();

        // Sink stalls 5 cycles mid-stream
        for (int i = 0; i < 12; i++) src.push_back(WIDTH'(8'h20 + i));
        repeat (4) step();
        p_ready = 0;
        for (int s = 0; s < 5; s++) begin
            step();
            check("stall_valid", 32'(m_valid_o), 32'(1));
            if (s >= 2) check("stall_rd_en", 32'(last_rd_en), 32'(0));
        end
        drain();

        // FIFO empty toggling every cycle
        for (int i = 0; i < 16; i++) src.push_back(WIDTH'($urandom));
        tgl_mode = 1'b1;
        repeat (40) step();
        drain();

        // Flush while streaming, then while stalled with a full skid buffer
        for (int i = 0; i < 16; i++) src.push_back(WIDTH'(8'h40 + i));
        repeat (4) step();
        flush_req = 1'b1;
        step();
        step();
        check("flush_stream_valid", 32'(m_valid_o), 32'(0));
        drain();
        for (int i = 0; i < 8; i++) src.push_back(WIDTH'(8'h60 + i));
        p_ready = 0;
        repeat (4) step();
        flush_req = 1'b1;
        step();
        step();
        check("flush_full_valid", 32'(m_valid_o), 32'(0));
        drain();

        // Reset mid-burst, then resume
        for (int i = 0; i < 16; i++) src.push_back(WIDTH'(8'h80 + i));
        repeat (5) step();
        reset_mid();
        repeat (2) step();
        rel_req = 1'b1;
        step();
        check("rerel_rd_en", 32'(last_rd_en), 32'(1));
        drain();

        // Randomised traffic with occasional flushes
        p_ready = 65; p_empty = 25;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) != 0) src.push_back(WIDTH'($urandom));
            if ($urandom_range(99) < 3) flush_req = 1'b1;
            if (i % 100 == 50) p_ready = int'($urandom_range(100, 20));
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
